program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time instruction-memory loader that sits directly upstream of turtle_cpu_core's instruction memory.
- Receives a framed byte stream over a valid/ready interface from the host link and writes 16-bit instruction words into instruction RAM at byte addresses.
- Holds the core in reset while loading and releases it once a frame has fully validated.
- Replaces preloaded-ROM-only boot for FPGA bring-up.

Parameters:
- INST_W, 16: instruction width in bits; must be a multiple of 8.
- I_ADDR_W, 12: instruction byte-address width; matches the core's instruction_addr.
- TIMEOUT_CYCLES, 1_000_000: maximum cycles allowed between bytes inside a frame.
- Derived localparam INST_W_BYTES = INST_W/8.
- Derived localparam MAX_WORDS = 2**I_ADDR_W / INST_W_BYTES.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- load_request  input  1  single-cycle pulse; starts or restarts a load
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction RAM write strobe
- imem_waddr  output  I_ADDR_W  instruction RAM byte address
- imem_wdata  output  INST_W  instruction word
- core_reset_n  output  1  active-low reset to turtle_cpu_core
- busy  output  1  a frame is in progress
- done  output  1  program loaded and core running
- error_code  output  3  loader_err_e; 0 = none

Behaviour:
- Clock/reset decision (fixed): one clock, clk; reset_n is asynchronous, active-low.
- Reset values: state = IDLE; all outputs 0. In particular core_reset_n=0, rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, error_code=0.
- All outputs are registered except rx_ready, which is decoded from state.
- Frame format: MAGIC 8'hA5, LEN_HI, LEN_LO, then LEN words sent low byte first, then CHK.
  - LEN is a 16-bit word count.
  - CHK is valid when (sum of all data bytes + CHK) mod 256 == 0.
- A byte is accepted on a clock edge where rx_valid && rx_ready.
- States: IDLE, HEADER, LEN_HI, LEN_LO, DATA_LO, DATA_HI, CHECKSUM, RUN, ERROR.
- rx_ready=1 only in HEADER through CHECKSUM.
- IDLE, RUN, ERROR: on load_request go to HEADER. Clear the word counter, checksum, timeout counter and error_code.
- HEADER: byte == MAGIC goes to LEN_HI; any other byte goes to ERROR with ERR_MAGIC.
- LEN_HI, then LEN_LO: after LEN_LO, LEN == 0 or LEN > MAX_WORDS goes to ERROR with ERR_LEN; otherwise go to DATA_LO.
- DATA_LO latches the low byte. DATA_HI then:
  - Cycle after the hi-byte handshake: imem_we=1 for exactly one cycle, imem_wdata={hi,lo}, imem_waddr=word_idx*INST_W_BYTES.
  - Then increment word_idx.
  - If word_idx reaches LEN go to CHECKSUM, else go to DATA_LO.
- CHECKSUM: on a good sum go to RUN; otherwise go to ERROR with ERR_CHECKSUM. Words already written remain in RAM, but the core stays in reset.
- RUN: core_reset_n=1 and done=1. core_reset_n rises 1 cycle after the CHK handshake.
- busy=1 in HEADER through CHECKSUM.
- Timeout applies in LEN_HI through CHECKSUM only; HEADER waits indefinitely for the host.
  - The counter clears on each accepted byte.
  - After TIMEOUT_CYCLES consecutive cycles with no handshake, go to ERROR with ERR_TIMEOUT.
- ERROR: core_reset_n=0. error_code is sticky until the next load_request.
- load_request in any state aborts the current operation and goes to HEADER. It has priority over a same-cycle byte handshake; that byte is consumed and discarded.
- load_request while in RUN re-asserts core reset (core_reset_n=0) on the next cycle.
- imem_waddr wrap is impossible, because LEN is bounded by MAX_WORDS.
- Asserting reset_n low mid-frame returns to IDLE immediately. RAM contents are undefined.

Decomposition:
- program_loader_pkg contains:
  - loader_state_e
  - loader_err_e {ERR_NONE=0, ERR_MAGIC=1, ERR_LEN=2, ERR_CHECKSUM=3, ERR_TIMEOUT=4}
  - LOADER_MAGIC = 8'hA5
- No sub-module is needed. The timeout counter and checksum accumulator stay inline.

Test Plan:
- Reset: reset_n low -> core_reset_n=0, rx_ready=0, busy=0, done=0, error_code=0. Then load_request -> rx_ready=1, busy=1.
- Good load: send A5 00 02 34 12 78 56 EC -> RAM writes (0x000, 0x1234) and (0x002, 0x5678), each imem_we one cycle wide. core_reset_n=1 and done=1 one cycle after EC.
- Bad magic: first byte 5A -> error_code=1, rx_ready=0, core_reset_n=0, no imem_we.
- Bad length: A5 08 01 (2049 > 2048) -> error_code=2 after LEN_LO, no imem_we.
- Bad checksum: A5 00 01 34 12 00 -> one write (0x000, 0x1234), then error_code=3, core_reset_n stays 0.
- Timeout and abort (TIMEOUT_CYCLES=16):
  - Stall after A5 00 -> error_code=4 after 16 idle cycles.
  - Then load_request mid-DATA_HI of a new frame, with a byte offered the same cycle -> byte discarded, state HEADER.
  - A full good reload then succeeds.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package program_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HEADER,
    LEN_HI,
    LEN_LO,
    DATA_LO,
    DATA_HI,
    CHECKSUM,
    RUN,
    ERROR
  } loader_state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MAGIC    = 3'd1,
    ERR_LEN      = 3'd2,
    ERR_CHECKSUM = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } loader_err_e;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  // True while a frame is being received (HEADER through CHECKSUM).
  function automatic logic in_frame(input loader_state_e s);
    return s inside {[HEADER:CHECKSUM]};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream from the host link into the loader (valid/ready handshake).
//   rx_data  : incoming byte
//   rx_valid : rx_data is valid
//   rx_ready : loader accepts a byte this cycle
interface program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: parses a framed byte stream (A5, LEN_HI, LEN_LO, LEN words
// low byte first, CHK), writes instruction words to RAM and releases the core
// from reset once the frame checksum validates.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   load_request   : single-cycle pulse, starts/restarts a load (aborts any frame)
//   rx             : host byte stream (slave side)
//   imem_we/waddr/wdata : instruction RAM write port (byte address)
//   core_reset_n   : active-low reset to the CPU core
//   busy, done     : frame in progress / program loaded and core running
//   error_code     : loader_err_e, sticky until the next load_request
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned INST_W         = 16,
  parameter int unsigned I_ADDR_W       = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_request,
  program_loader_if.slave     rx,
  output logic                imem_we,
  output logic [I_ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0]   imem_wdata,
  output logic                core_reset_n,
  output logic                busy,
  output logic                done,
  output logic [2:0]          error_code
);

  localparam int unsigned INST_W_BYTES = INST_W / 8;
  localparam int unsigned MAX_WORDS    = (2 ** I_ADDR_W) / INST_W_BYTES;
  localparam int unsigned TO_W         = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_e   state_q, state_d;
  loader_err_e     err_q, err_d;
  logic [15:0]     word_idx_q, word_idx_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      sum_q, sum_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic                imem_we_d;
  logic [I_ADDR_W-1:0] imem_waddr_d;
  logic [INST_W-1:0]   imem_wdata_d;
  logic                core_reset_n_d;
  logic                busy_d;
  logic                done_d;

  logic hs;
  logic timed;

  assign rx.rx_ready = in_frame(state_q);
  assign hs          = rx.rx_valid && rx.rx_ready;
  // HEADER waits for the host indefinitely; only later frame bytes time out.
  assign timed       = state_q inside {[LEN_HI:CHECKSUM]};
  assign error_code  = err_q;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      err_q        <= ERR_NONE;
      word_idx_q   <= '0;
      len_q        <= '0;
      lo_q         <= '0;
      sum_q        <= '0;
      to_cnt_q     <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      core_reset_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      word_idx_q   <= word_idx_d;
      len_q        <= len_d;
      lo_q         <= lo_d;
      sum_q        <= sum_d;
      to_cnt_q     <= to_cnt_d;
      imem_we      <= imem_we_d;
      imem_waddr   <= imem_waddr_d;
      imem_wdata   <= imem_wdata_d;
      core_reset_n <= core_reset_n_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    lo_d       = lo_q;
    sum_d      = sum_q;
    to_cnt_d   = to_cnt_q;

    if (load_request) begin
      // Abort wins over a same-cycle handshake; that byte is dropped.
      state_d    = HEADER;
      err_d      = ERR_NONE;
      word_idx_d = '0;
      sum_d      = '0;
      to_cnt_d   = '0;
    end else begin
      if (timed) begin
        to_cnt_d = hs ? '0 : to_cnt_q + TO_W'(1);
      end

      unique case (state_q)
        HEADER: if (hs) begin
          if (rx.rx_data == LOADER_MAGIC) begin
            state_d = LEN_HI;
          end else begin
            state_d = ERROR;
            err_d   = ERR_MAGIC;
          end
        end
        LEN_HI: if (hs) begin
          len_d[15:8] = rx.rx_data;
          state_d     = LEN_LO;
        end
        LEN_LO: if (hs) begin
          len_d[7:0] = rx.rx_data;
          if (({len_q[15:8], rx.rx_data} == 16'd0) ||
              (32'({len_q[15:8], rx.rx_data}) > MAX_WORDS)) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else begin
            state_d = DATA_LO;
          end
        end
        DATA_LO: if (hs) begin
          lo_d    = rx.rx_data;
          sum_d   = sum_q + rx.rx_data;
          state_d = DATA_HI;
        end
        DATA_HI: if (hs) begin
          sum_d      = sum_q + rx.rx_data;
          word_idx_d = word_idx_q + 16'd1;
          state_d    = (word_idx_d == len_q) ? CHECKSUM : DATA_LO;
        end
        CHECKSUM: if (hs) begin
          if (8'(sum_q + rx.rx_data) == 8'd0) begin
            state_d = RUN;
          end else begin
            state_d = ERROR;
            err_d   = ERR_CHECKSUM;
          end
        end
        default: ;
      endcase

      if (timed && !hs && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
        state_d  = ERROR;
        err_d    = ERR_TIMEOUT;
        to_cnt_d = '0;
      end
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    imem_we_d      = 1'b0;
    imem_waddr_d   = imem_waddr;
    imem_wdata_d   = imem_wdata;
    core_reset_n_d = (state_d == RUN);
    done_d         = (state_d == RUN);
    busy_d         = in_frame(state_d);

    if (!load_request && (state_q == DATA_HI) && hs) begin
      imem_we_d    = 1'b1;
      imem_waddr_d = I_ADDR_W'(word_idx_q * INST_W_BYTES);
      imem_wdata_d = INST_W'({rx.rx_data, lo_q});
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk;
  logic        reset_n;
  logic        load_request;
  logic        imem_we;
  logic [11:0] imem_waddr;
  logic [15:0] imem_wdata;
  logic        core_reset_n;
  logic        busy;
  logic        done;
  logic [2:0]  error_code;

  int checks = 0;
  int errors = 0;

  logic [27:0] wr_q[$];

  program_loader_if rx_if ();

  program_loader #(
    .INST_W(16),
    .I_ADDR_W(12),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load_request(load_request),
    .rx(rx_if),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .core_reset_n(core_reset_n),
    .busy(busy),
    .done(done),
    .error_code(error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every RAM write strobe; a pulse wider than one cycle shows up twice.
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) wr_q.push_back({imem_waddr, imem_wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; the byte is taken on the rising edge between.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    while (rx_if.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("send_ready", 32'(rx_if.rx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load_request = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_request = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [11:0] a, input logic [15:0] d);
    check({tag, "_present"}, 32'(wr_q.size() > 0), 32'd1);
    if (wr_q.size() > 0) check(tag, 32'(wr_q.pop_front()), 32'({a, d}));
  endtask

  initial begin
    reset_n        = 1'b0;
    load_request   = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
    check("rst_rx_ready", 32'(rx_if.rx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error_code", 32'(error_code), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_if.rx_ready), 32'd0);

    // Good load
    pulse_load();
    check("load_rx_ready", 32'(rx_if.rx_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56);
    check("good_pre_chk_core", 32'(core_reset_n), 32'd0);
    check("good_pre_chk_done", 32'(done), 32'd0);
    send_byte(8'hEC);
    check("good_core_reset_n", 32'(core_reset_n), 32'd1);
    check("good_done", 32'(done), 32'd1);
    check("good_busy", 32'(busy), 32'd0);
    check("good_rx_ready", 32'(rx_if.rx_ready), 32'd0);
    check("good_error_code", 32'(error_code), 32'd0);
    check("good_nwrites", 32'(wr_q.size()), 32'd2);
    expect_write("good_wr0", 12'h000, 16'h1234);
    expect_write("good_wr1", 12'h002, 16'h5678);
    wr_q.delete();

    // Restart from RUN re-asserts core reset
    pulse_load();
    check("rerun_core_reset_n", 32'(core_reset_n), 32'd0);
    check("rerun_done", 32'(done), 32'd0);
    check("rerun_busy", 32'(busy), 32'd1);

    // Bad magic
    send_byte(8'h5A);
    check("magic_error_code", 32'(error_code), 32'd1);
    check("magic_rx_ready", 32'(rx_if.rx_ready), 32'd0);
    check("magic_core_reset_n", 32'(core_reset_n), 32'd0);
    check("magic_busy", 32'(busy), 32'd0);
    check("magic_nwrites", 32'(wr_q.size()), 32'd0);

    // Bad length: 0x0801 words exceeds 2048
    pulse_load();
    check("len_error_cleared", 32'(error_code), 32'd0);
    send_byte(8'hA5); send_byte(8'h08);
    check("len_mid_error_code", 32'(error_code), 32'd0);
    send_byte(8'h01);
    check("len_error_code", 32'(error_code), 32'd2);
    check("len_nwrites", 32'(wr_q.size()), 32'd0);

    // Bad checksum
    pulse_load();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h34); send_byte(8'h12);
    check("chk_nwrites", 32'(wr_q.size()), 32'd1);
    expect_write("chk_wr0", 12'h000, 16'h1234);
    send_byte(8'h00);
    check("chk_error_code", 32'(error_code), 32'd3);
    check("chk_core_reset_n", 32'(core_reset_n), 32'd0);
    check("chk_done", 32'(done), 32'd0);

    // Timeout after 16 idle cycles in LEN_LO
    pulse_load();
    send_byte(8'hA5); send_byte(8'h00);
    repeat (15) @(negedge clk);
    check("to_15_error_code", 32'(error_code), 32'd0);
    check("to_15_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("to_16_error_code", 32'(error_code), 32'd4);
    check("to_16_busy", 32'(busy), 32'd0);

    // Abort in DATA_HI with a byte offered the same cycle
    pulse_load();
    check("abort_error_cleared", 32'(error_code), 32'd0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h34);
    rx_if.rx_data  = 8'h12;
    rx_if.rx_valid = 1'b1;
    load_request   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    load_request   = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_rx_ready", 32'(rx_if.rx_ready), 32'd1);
    check("abort_error_code", 32'(error_code), 32'd0);
    check("abort_nwrites", 32'(wr_q.size()), 32'd0);

    // Full good reload after the abort
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56);
    send_byte(8'hEC);
    check("reload_core_reset_n", 32'(core_reset_n), 32'd1);
    check("reload_done", 32'(done), 32'd1);
    check("reload_error_code", 32'(error_code), 32'd0);
    check("reload_nwrites", 32'(wr_q.size()), 32'd2);
    expect_write("reload_wr0", 12'h000, 16'h1234);
    expect_write("reload_wr1", 12'h002, 16'h5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
